// File: rtl/dbg_apb_reg_slave_if.sv
// Debug APB completer slot: request signals from the bus, ready/rdata back to it.
interface dbg_apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  sel;
    logic                  enable;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrobe;
    logic                  ready;
    logic [31:0]           rdata;

    modport master (output sel, enable, wr_rd, addr, wdata, wstrobe, input ready, rdata);
    modport slave  (input sel, enable, wr_rd, addr, wdata, wstrobe, output ready, rdata);
endinterface

// File: rtl/dbg_apb_reg_slave.sv
// Debug APB register bank: NR_REGS x 32-bit control regs (reg 0 = read-only ID),
// programmable wait states, byte strobes, write pulses and a saturating error counter.
module dbg_apb_reg_slave #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          NR_REGS     = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hDB60_0001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dbg_apb_reg_slave_if.slave      bus,
    output logic [NR_REGS*32-1:0]   regs_q,
    output logic [NR_REGS-1:0]      wr_pulse,
    output logic [7:0]              err_cnt
);
    localparam int         IDX_W = $clog2(NR_REGS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:2]   addr_q;
    logic                    wr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              strb_q;
    logic [NR_REGS-1:0][31:0] regs;

    logic             load, done, err_inc, ready_c, in_range, commit_wr;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_val;

    assign idx       = addr_q[IDX_W+1:2];
    assign in_range  = (addr_q[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign commit_wr = done && wr_q && in_range && (idx != '0) && (strb_q != 4'h0);
    assign rd_val    = (idx == '0) ? ID_VALUE : regs[idx];

    // Gated by rst_n so a bus still showing sel&enable cannot raise ready during reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        done      = 1'b0;
        err_inc   = 1'b0;
        ready_c   = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (bus.sel && !bus.enable) begin
                        state_nxt = ACCESS;
                        load      = 1'b1;
                    end else if (bus.sel && bus.enable) begin
                        ready_c = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                ACCESS: begin
                    if (!bus.sel) begin
                        state_nxt = IDLE;
                        err_inc   = 1'b1;
                    end else if (!bus.enable) begin
                        load    = 1'b1;
                        err_inc = 1'b1;
                    end else if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        ready_c   = 1'b1;
                        done      = 1'b1;
                        state_nxt = IDLE;
                        err_inc   = !in_range;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (load) cnt_nxt = WS;
    end

    assign bus.ready = ready_c;
    // Bus ORs all slots, so rdata must be exactly zero outside a read ready cycle.
    assign bus.rdata = (state == ACCESS && bus.sel && bus.enable && ready_c && !wr_q && in_range)
                       ? rd_val : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            regs     <= '0;
            wr_pulse <= '0;
            err_cnt  <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wr_pulse <= '0;
            if (load) begin
                addr_q  <= bus.addr[ADDR_WIDTH-1:2];
                wr_q    <= bus.wr_rd;
                wdata_q <= bus.wdata;
                strb_q  <= bus.wstrobe;
            end
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            if (commit_wr) begin
                wr_pulse[idx] <= 1'b1;
                for (int n = 0; n < 4; n++)
                    if (strb_q[n]) regs[idx][8*n +: 8] <= wdata_q[8*n +: 8];
            end
        end
    end

    for (genvar k = 0; k < NR_REGS; k++) begin : g_regs_q
        if (k == 0) begin : g_id
            assign regs_q[31:0] = ID_VALUE;
        end else begin : g_rw
            assign regs_q[32*k +: 32] = regs[k];
        end
    end
endmodule

// File: tb/tb_dbg_apb_reg_slave.sv
// Scoreboarded bench: two slaves (1 and 3 wait states) on a shared OR-ed bus.
module tb_dbg_apb_reg_slave;
    logic clk = 1'b0;
    logic rst_a_n = 1'b0, rst_b_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel_a = 0, sel_b = 0, enable = 0, wr_rd = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0]  wstrobe = 0;

    dbg_apb_reg_slave_if #(.ADDR_WIDTH(32)) bus_a();
    dbg_apb_reg_slave_if #(.ADDR_WIDTH(32)) bus_b();
    assign bus_a.sel = sel_a;  assign bus_b.sel = sel_b;
    assign bus_a.enable = enable; assign bus_b.enable = enable;
    assign bus_a.wr_rd = wr_rd;   assign bus_b.wr_rd = wr_rd;
    assign bus_a.addr = addr;     assign bus_b.addr = addr;
    assign bus_a.wdata = wdata;   assign bus_b.wdata = wdata;
    assign bus_a.wstrobe = wstrobe; assign bus_b.wstrobe = wstrobe;

    logic [255:0] regs_a, regs_b;
    logic [7:0]   wp_a, wp_b, err_a, err_b;

    dbg_apb_reg_slave #(.WAIT_STATES(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(bus_a), .regs_q(regs_a), .wr_pulse(wp_a), .err_cnt(err_a));
    dbg_apb_reg_slave #(.WAIT_STATES(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(bus_b), .regs_q(regs_b), .wr_pulse(wp_b), .err_cnt(err_b));

    wire        rdy_any   = bus_a.ready | bus_b.ready;
    wire [31:0] rdata_any = bus_a.rdata | bus_b.rdata;

    typedef struct { logic [31:0] rdata; int cyc; } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every ready seen on the bus consumes one expected response.
    always @(negedge clk) begin
        if (rdy_any) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_ready: got ready want none (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", 256'(rdata_any), 256'(e.rdata));
                check("ready_cyc", 256'(cyc), 256'(e.cyc));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the commit edge with the bus idle.
    task automatic xfer(input bit b, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd);
        int ws = b ? 3 : 1;
        bit got = 0;
        if (b) sel_b = 1; else sel_a = 1;
        enable = 0; wr_rd = wr; addr = a; wdata = d; wstrobe = s;
        sb.push_back('{rdata: wr ? 32'h0 : exp_rd, cyc: cyc + 1 + ws});
        @(posedge clk); #1 enable = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rdy_any;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL xfer_timeout: got no ready want ready (addr %0h)", a);
        end
        @(posedge clk); #1;
        sel_a = 0; sel_b = 0; enable = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_ready", 256'(rdy_any), 256'(0));
        check("rst_rdata", 256'(rdata_any), 256'(0));
        check("rst_err", 256'(err_a), 256'(0));
        check("rst_regs", regs_a, {224'h0, 32'hDB60_0001});
        rst_a_n = 1; rst_b_n = 1;
        idle(1);

        // write 0x12345678 to reg1
        xfer(0, 1, 32'h4, 32'h1234_5678, 4'hF, 0);
        check("t1_reg1", 256'(regs_a[63:32]), 256'(32'h1234_5678));
        check("t1_pulse", 256'(wp_a), 256'(8'b0000_0010));
        idle(1);
        check("t1_pulse_clr", 256'(wp_a), 256'(0));

        // ID register: read, write attempt, read again
        xfer(0, 0, 32'h0, 0, 4'hF, 32'hDB60_0001);
        check("t2_rdata_after", 256'(rdata_any), 256'(0));
        xfer(0, 1, 32'h0, 32'hFFFF_FFFF, 4'hF, 0);
        check("t2_no_pulse", 256'(wp_a), 256'(0));
        xfer(0, 0, 32'h0, 0, 4'hF, 32'hDB60_0001);
        check("t2_err", 256'(err_a), 256'(0));

        // byte strobes
        xfer(0, 1, 32'h4, 32'hAABB_CCDD, 4'b0101, 0);
        check("t3_reg1", 256'(regs_a[63:32]), 256'(32'h12BB_56DD));
        check("t3_pulse", 256'(wp_a), 256'(8'b0000_0010));
        xfer(0, 1, 32'h4, 32'h0000_0000, 4'h0, 0);
        check("t3_reg1_nop", 256'(regs_a[63:32]), 256'(32'h12BB_56DD));
        check("t3_nop_pulse", 256'(wp_a), 256'(0));
        xfer(0, 0, 32'h7, 0, 4'hF, 32'h12BB_56DD);

        // out of range, then ACCESS without SETUP
        xfer(0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0);
        check("t4_err1", 256'(err_a), 256'(1));
        check("t4_regs", regs_a, {192'h0, 32'h12BB_56DD, 32'hDB60_0001});
        check("t4_pulse", 256'(wp_a), 256'(0));
        xfer(0, 0, 32'h20, 0, 4'hF, 32'h0);
        check("t4_err2", 256'(err_a), 256'(2));
        idle(1);
        sel_a = 1; enable = 1; wr_rd = 1; addr = 32'h8; wdata = 32'h5555_5555; wstrobe = 4'hF;
        sb.push_back('{rdata: 32'h0, cyc: cyc});
        idle(1);
        sel_a = 0; enable = 0;
        check("t4_err3", 256'(err_a), 256'(3));
        check("t4_reg2", 256'(regs_a[95:64]), 256'(0));

        // 3 wait states: back-to-back write/read of reg2
        xfer(1, 1, 32'h8, 32'hCAFE_F00D, 4'hF, 0);
        xfer(1, 0, 32'h8, 0, 4'hF, 32'hCAFE_F00D);
        check("t5_reg2", 256'(regs_b[95:64]), 256'(32'hCAFE_F00D));
        // abort in 2nd ACCESS cycle
        sel_b = 1; enable = 0; wr_rd = 1; addr = 32'hC; wdata = 32'h1111_1111; wstrobe = 4'hF;
        idle(1); enable = 1;
        idle(1); sel_b = 0; enable = 0;
        idle(1);
        check("t5_abort_err", 256'(err_b), 256'(1));
        check("t5_abort_reg3", 256'(regs_b[127:96]), 256'(0));
        check("t5_abort_pulse", 256'(wp_b), 256'(0));

        // reset during ACCESS wait
        sel_b = 1; enable = 0; wr_rd = 0; addr = 32'h8;
        idle(1); enable = 1;
        idle(1);
        rst_b_n = 0;
        #1;
        check("t6_rst_ready", 256'(rdy_any), 256'(0));
        check("t6_rst_rdata", 256'(rdata_any), 256'(0));
        check("t6_rst_reg2", 256'(regs_b[95:64]), 256'(0));
        check("t6_rst_err", 256'(err_b), 256'(0));
        idle(1); sel_b = 0; enable = 0;
        rst_b_n = 1;
        idle(1);

        // saturation: repeated SETUP while in ACCESS counts one error per cycle
        sel_b = 1; enable = 0; addr = 32'h4;
        idle(1);
        idle(254);
        check("t6_err_fe", 256'(err_b), 256'(8'hFE));
        idle(46);
        check("t6_err_ff", 256'(err_b), 256'(8'hFF));
        sel_b = 0;
        idle(1);
        check("t6_err_hold", 256'(err_b), 256'(8'hFF));

        idle(3);
        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
